// File: rtl/snake_sprite_reader.sv
// Two-stage pixel reader for a 16x16 sprite ROM: box test and mirrored
// addressing in stage 1, colour sample and key-out in stage 2.
module snake_sprite_reader #(
  parameter int          X_W       = 10,
  parameter int          Y_W       = 10,
  parameter logic [23:0] KEY_COLOR = 24'h181b1d
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_sof,
  input  logic [X_W-1:0] i_pos_x,
  input  logic [Y_W-1:0] i_pos_y,
  input  logic [1:0]     i_dir,
  input  logic           i_valid,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic [7:0]     o_rom_addr,
  input  logic [23:0]    i_rom_data,
  output logic           o_valid,
  output logic           o_hit,
  output logic [23:0]    o_rgb,
  output logic           dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [X_W:0] SPAN_X = (X_W+1)'(16);
  localparam logic [Y_W:0] SPAN_Y = (Y_W+1)'(16);

  state_t         state_q, state_d;
  logic [X_W-1:0] anchor_x_q;
  logic [Y_W-1:0] anchor_y_q;
  logic [1:0]     dir_q;

  logic [X_W-1:0] ax;
  logic [Y_W-1:0] ay;
  logic [1:0]     dir_eff;
  logic           active_eff;
  logic           in_x, in_y, in_box;
  logic [3:0]     u, v, col, row;
  logic           s1_valid, s1_in;
  logic           hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_sof) state_d = ACTIVE;
  end

  assign dbg_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      anchor_x_q <= '0;
      anchor_y_q <= '0;
      dir_q      <= '0;
    end else if (i_sof) begin
      anchor_x_q <= i_pos_x;
      anchor_y_q <= i_pos_y;
      dir_q      <= i_dir;
    end
  end

  // The pixel arriving with i_sof already uses the new anchor and dir.
  assign ax         = i_sof ? i_pos_x : anchor_x_q;
  assign ay         = i_sof ? i_pos_y : anchor_y_q;
  assign dir_eff    = i_sof ? i_dir   : dir_q;
  assign active_eff = (state_q == ACTIVE) || i_sof;

  // One extra bit keeps anchor+16 from wrapping, so the box is clipped.
  assign in_x = ({1'b0, i_x} >= {1'b0, ax}) && ({1'b0, i_x} < ({1'b0, ax} + SPAN_X));
  assign in_y = ({1'b0, i_y} >= {1'b0, ay}) && ({1'b0, i_y} < ({1'b0, ay} + SPAN_Y));
  assign in_box = active_eff && in_x && in_y;

  assign u   = i_x[3:0] - ax[3:0];
  assign v   = i_y[3:0] - ay[3:0];
  assign col = dir_eff[0] ? ~u : u;
  assign row = dir_eff[1] ? ~v : v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_addr <= 8'd0;
      s1_valid   <= 1'b0;
      s1_in      <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      s1_in    <= in_box && i_valid;
      if (i_valid) o_rom_addr <= in_box ? {row, col} : 8'd0;
    end
  end

  assign hit = s1_in && (i_rom_data != KEY_COLOR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_hit   <= 1'b0;
      o_rgb   <= 24'd0;
    end else begin
      o_valid <= s1_valid;
      o_hit   <= hit;
      o_rgb   <= hit ? i_rom_data : 24'd0;
    end
  end

endmodule

// File: tb/tb_snake_sprite_reader.sv
// Directed and random pixel streams against a bench-side sprite model,
// with expected pixels queued at drive time and compared on o_valid.
module tb_snake_sprite_reader;

  localparam int          X_W = 10;
  localparam int          Y_W = 10;
  localparam logic [23:0] KEY = 24'h181b1d;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sof = 1'b0;
  logic [X_W-1:0] pos_x = '0;
  logic [Y_W-1:0] pos_y = '0;
  logic [1:0]     dir = '0;
  logic           valid = 1'b0;
  logic [X_W-1:0] x = '0;
  logic [Y_W-1:0] y = '0;
  logic [7:0]     rom_addr;
  logic [23:0]    rom_data;
  logic           out_valid, out_hit;
  logic [23:0]    out_rgb;
  logic           dbg_state;

  always #5 clk = ~clk;

  snake_sprite_reader #(.X_W(X_W), .Y_W(Y_W), .KEY_COLOR(KEY)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof),
    .i_pos_x(pos_x), .i_pos_y(pos_y), .i_dir(dir),
    .i_valid(valid), .i_x(x), .i_y(y),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_valid(out_valid), .o_hit(out_hit), .o_rgb(out_rgb),
    .dbg_state(dbg_state)
  );

  function automatic logic [23:0] rom_f(input logic [7:0] a);
    if (a == 8'd0 || a == 8'h77) return KEY;
    if (a == 8'd35)              return 24'hc3ed80;
    return {a, ~a, a ^ 8'h5a};
  endfunction

  assign rom_data = rom_f(rom_addr);

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [24:0] exp_q[$];
  logic        mv1 = 1'b0, mv2 = 1'b0;
  logic [7:0]  a_model = 8'd0;
  logic        m_active = 1'b0;
  int          m_ax = 0, m_ay = 0;
  logic [1:0]  m_dir = 2'd0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [24:0] e;
    check("o_valid", 33'(out_valid), 33'(mv2));
    check("rom_addr", 33'(rom_addr), 33'(a_model));
    check("state", 33'(dbg_state), 33'(m_active));
    if (mv2) begin
      check("sb_nonempty", 33'(exp_q.size() != 0), 33'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("hit_rgb", 33'({out_hit, out_rgb}), 33'(e));
      end
    end else begin
      check("idle_out", 33'({out_hit, out_rgb}), 33'(0));
    end
  endtask

  task automatic step(input logic v_in, input int xi, input int yi, input logic s,
                      input int ppx, input int ppy, input logic [1:0] pdir);
    int          u, w, col, row;
    logic        inbox, h;
    logic [7:0]  addr;
    logic [23:0] c;
    @(negedge clk);
    check_outputs();
    mv2 = mv1;
    mv1 = v_in;
    valid = v_in;
    x = X_W'(xi);
    y = Y_W'(yi);
    sof = s;
    pos_x = X_W'(ppx);
    pos_y = Y_W'(ppy);
    dir = pdir;
    if (s) begin
      m_active = 1'b1;
      m_ax = ppx;
      m_ay = ppy;
      m_dir = pdir;
    end
    if (v_in) begin
      inbox = m_active && xi >= m_ax && xi < m_ax + 16 && yi >= m_ay && yi < m_ay + 16;
      u = (xi - m_ax) & 15;
      w = (yi - m_ay) & 15;
      col = m_dir[0] ? 15 - u : u;
      row = m_dir[1] ? 15 - w : w;
      addr = inbox ? 8'(row * 16 + col) : 8'd0;
      a_model = addr;
      c = rom_f(addr);
      h = inbox && (c != KEY);
      exp_q.push_back({h, h ? c : 24'd0});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    sof = 1'b0;
    #1;
    check("rst_valid", 33'(out_valid), 33'(0));
    check("rst_hit_rgb", 33'({out_hit, out_rgb}), 33'(0));
    check("rst_addr", 33'(rom_addr), 33'(0));
    check("rst_state", 33'(dbg_state), 33'(0));
    mv1 = 1'b0;
    mv2 = 1'b0;
    a_model = 8'd0;
    m_active = 1'b0;
    m_ax = 0;
    m_ay = 0;
    m_dir = 2'd0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int npx, npy, base_x, base_y, xi, yi;
    logic s, v;
    logic [1:0] nd;

    do_reset();

    // No anchor yet: every pixel passes through with no hit.
    for (int i = 0; i <= 20; i++)
      step(1'b1, i, i, 1'b0, $urandom_range(0, 20), $urandom_range(0, 20), 2'd0);

    step(1'b1, 103, 52, 1'b1, 100, 50, 2'b00);
    step(1'b1, 100, 50, 1'b0, 7, 7, 2'b11);
    step(1'b1, 100, 50, 1'b1, 100, 50, 2'b11);
    step(1'b1, 101, 50, 1'b1, 100, 50, 2'b01);
    step(1'b0, 0, 0, 1'b0, 0, 0, 2'b00);

    step(1'b1, 99, 50, 1'b1, 100, 50, 2'b00);
    step(1'b1, 116, 50, 1'b0, 0, 0, 2'b00);
    step(1'b1, 100, 66, 1'b0, 0, 0, 2'b00);
    step(1'b1, 115, 65, 1'b0, 0, 0, 2'b00);
    step(1'b1, 100, 49, 1'b0, 0, 0, 2'b00);

    // Anchor near the right edge: the box clips instead of wrapping to x=0.
    step(1'b1, 1023, 205, 1'b1, 1020, 200, 2'b00);
    step(1'b1, 2, 205, 1'b0, 0, 0, 2'b00);
    step(1'b1, 0, 205, 1'b0, 0, 0, 2'b00);
    step(1'b1, 1020, 200, 1'b0, 0, 0, 2'b00);

    step(1'b1, 305, 305, 1'b1, 300, 300, 2'b00);
    step(1'b1, 305, 305, 1'b1, 305, 305, 2'b00);
    step(1'b1, 306, 306, 1'b0, 0, 0, 2'b00);
    step(1'b1, 312, 312, 1'b0, 0, 0, 2'b00);
    step(1'b0, 0, 0, 1'b1, 500, 500, 2'b10);
    step(1'b1, 500, 500, 1'b0, 0, 0, 2'b00);

    for (int i = 0; i < 80; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0);
      npx = $urandom_range(0, 1023);
      npy = $urandom_range(0, 1023);
      nd = 2'($urandom_range(0, 3));
      base_x = s ? npx : m_ax;
      base_y = s ? npy : m_ay;
      xi = (base_x + $urandom_range(0, 19) - 2) & 1023;
      yi = (base_y + $urandom_range(0, 19) - 2) & 1023;
      step(v, xi, yi, s, npx, npy, nd);
    end

    step(1'b1, 200, 200, 1'b1, 200, 200, 2'b00);
    step(1'b1, 201, 200, 1'b0, 0, 0, 2'b00);
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 200 + i, 200, 1'b0, 200, 200, 2'b00);
    step(1'b1, 203, 201, 1'b1, 200, 200, 2'b00);
    step(1'b1, 204, 201, 1'b0, 0, 0, 2'b00);

    for (int i = 0; i < 3; i++)
      step(1'b0, 0, 0, 1'b0, 0, 0, 2'b00);
    check("sb_drained", 33'(exp_q.size()), 33'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
